// File: rtl/instr_issue_unit.sv
// instr_issue_unit
//   Program-sequencing stage that sits directly in front of the datapath.
//   It holds a loadable program store of {InitSel, DataInit, Instruction}
//   entries. After a start pulse it replays the first len entries in order,
//   one entry every two clocks, which matches the datapath's half-rate
//   sampling. Between entries it drives NOP/0/0 so the datapath never
//   executes or initialises the same entry twice.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   load_we/addr/instr/   program store write port; honoured only in IDLE
//   load_data/load_init     or DONE
//   start, prog_len       begin a run of min(prog_len, DEPTH) entries
//   stall                 downstream not ready; holds the current issue
//   abort                 cancel the run and return to IDLE
//   Instruction/DataInit/ registered entry fields driven to the datapath
//   InitSel
//   issue_valid           outputs carry a real entry this cycle
//   pc                    index of the entry being fetched or issued
//   busy, done            state is FETCH/ISSUE, state is DONE
module instr_issue_unit #(
    parameter int               ISIZE = 16,
    parameter int               DSIZE = 16,
    parameter int               DEPTH = 64,
    parameter int               AW    = 6,
    parameter logic [ISIZE-1:0] NOP   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_we,
    input  logic [AW-1:0]    load_addr,
    input  logic [ISIZE-1:0] load_instr,
    input  logic [DSIZE-1:0] load_data,
    input  logic             load_init,
    input  logic             start,
    input  logic [AW:0]      prog_len,
    input  logic             stall,
    input  logic             abort,
    output logic [ISIZE-1:0] Instruction,
    output logic [DSIZE-1:0] DataInit,
    output logic             InitSel,
    output logic             issue_valid,
    output logic [AW-1:0]    pc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam int          EW      = ISIZE + DSIZE + 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PC_ONE = AW'(1);

    state_t            state;
    state_t            state_next;
    logic [AW:0]       len;
    logic [AW:0]       len_in;
    logic              last;
    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     entry;
    logic              store_open;

    assign store_open = (state == S_IDLE) || (state == S_DONE);
    assign len_in     = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    // len is at least 1 whenever ISSUE is reachable, so len-1 never underflows there.
    assign last       = ({1'b0, pc} == (len - LEN_ONE));
    assign entry      = mem[pc];

    // Program store: no reset, so a program survives reset and abort.
    always_ff @(posedge clk) begin
        if (load_we && store_open) begin
            mem[load_addr] <= {load_init, load_data, load_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_next = (len_in == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: state_next = S_ISSUE;
                S_ISSUE: begin
                    if (!stall) begin
                        state_next = last ? S_DONE : S_FETCH;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Output fields are loaded straight from the store on the FETCH->ISSUE
    // edge, which gives the one-cycle synchronous read and registered outputs.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            pc          <= '0;
            len         <= '0;
            Instruction <= NOP;
            DataInit    <= '0;
            InitSel     <= 1'b0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            busy <= (state_next == S_FETCH) || (state_next == S_ISSUE);
            done <= (state_next == S_DONE);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len <= len_in;
                        pc  <= '0;
                    end
                end
                S_FETCH: begin
                    Instruction <= entry[ISIZE-1:0];
                    DataInit    <= entry[ISIZE+DSIZE-1:ISIZE];
                    InitSel     <= entry[EW-1];
                    issue_valid <= 1'b1;
                end
                S_ISSUE: begin
                    if (!stall) begin
                        Instruction <= NOP;
                        DataInit    <= '0;
                        InitSel     <= 1'b0;
                        issue_valid <= 1'b0;
                        if (!last) begin
                            pc <= pc + PC_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issue_unit.sv
// tb_instr_issue_unit
//   Directed tests for instr_issue_unit: reset, in-order half-rate issue,
//   stall hold, zero length, length clamp at DEPTH, abort with start, store
//   write lockout during a run, and a small datapath accumulator chained to
//   the issued stream.
module tb_instr_issue_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_we;
    logic [5:0]  load_addr;
    logic [15:0] load_instr;
    logic [15:0] load_data;
    logic        load_init;
    logic        start;
    logic [6:0]  prog_len;
    logic        stall;
    logic        abort;
    logic [15:0] Instruction;
    logic [15:0] DataInit;
    logic        InitSel;
    logic        issue_valid;
    logic [5:0]  pc;
    logic        busy;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    instr_issue_unit #(
        .ISIZE(16), .DSIZE(16), .DEPTH(64), .AW(6), .NOP(16'h0)
    ) dut (
        .clk(clk), .reset(reset),
        .load_we(load_we), .load_addr(load_addr), .load_instr(load_instr),
        .load_data(load_data), .load_init(load_init),
        .start(start), .prog_len(prog_len), .stall(stall), .abort(abort),
        .Instruction(Instruction), .DataInit(DataInit), .InitSel(InitSel),
        .issue_valid(issue_valid), .pc(pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Advance one clock; afterwards outputs reflect that edge and new
    // input values will be seen at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pat_instr(int i);
        return 16'hA000 + i[15:0];
    endfunction

    function automatic logic [15:0] pat_data(int i);
        return 16'h0100 + i[15:0];
    endfunction

    task automatic load_entry(int a, logic [15:0] ins, logic [15:0] dat, logic ini);
        load_we    = 1'b1;
        load_addr  = a[5:0];
        load_instr = ins;
        load_data  = dat;
        load_init  = ini;
        tick();
        load_we    = 1'b0;
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 64; i++) begin
            load_entry(i, pat_instr(i), pat_data(i), i[0]);
        end
    endtask

    // Issue start with length n; returns at cycle 0 of the run (start seen).
    task automatic do_start(int n);
        start    = 1'b1;
        prog_len = n[6:0];
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tests_run++;
        if ({Instruction, DataInit, InitSel, issue_valid, pc, busy, done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: instr=%h data=%h init=%b valid=%b pc=%0d busy=%b done=%b, required all zero",
                     Instruction, DataInit, InitSel, issue_valid, pc, busy, done);
        end
    endtask

    task automatic test_basic();
        logic [15:0] ei [3] = '{16'h0000, 16'h0000, 16'h3A10};
        logic [15:0] ed [3] = '{16'h0000, 16'h1234, 16'h0000};
        logic        en [3] = '{1'b1, 1'b1, 1'b0};
        load_entry(0, ei[0], ed[0], en[0]);
        load_entry(1, ei[1], ed[1], en[1]);
        load_entry(2, ei[2], ed[2], en[2]);
        do_start(3);
        // Now at cycle 1 after start.
        for (int c = 1; c <= 7; c++) begin
            logic        v;
            logic [15:0] xi, xd;
            logic        xn;
            v  = (c == 2) || (c == 4) || (c == 6);
            xi = v ? ei[(c-2)/2] : 16'h0;
            xd = v ? ed[(c-2)/2] : 16'h0;
            xn = v ? en[(c-2)/2] : 1'b0;
            tests_run++;
            if ({issue_valid, Instruction, DataInit, InitSel, done} !== {v, xi, xd, xn, (c == 7)}) begin
                tests_failed++;
                $display("FAIL basic_cycle%0d: valid=%b instr=%h data=%h init=%b done=%b, required valid=%b instr=%h data=%h init=%b done=%b",
                         c, issue_valid, Instruction, DataInit, InitSel, done, v, xi, xd, xn, (c == 7));
            end
            if (c < 7) tick();
        end
    endtask

    task automatic test_stall();
        do_start(3);
        tick(); tick(); tick();
        // Cycle 4: entry 1 just issued.
        tests_run++;
        if ({issue_valid, DataInit, pc} !== {1'b1, 16'h1234, 6'd1}) begin
            tests_failed++;
            $display("FAIL stall_first_issue: valid=%b data=%h pc=%0d, required valid=1 data=1234 pc=1",
                     issue_valid, DataInit, pc);
        end
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if ({issue_valid, Instruction, DataInit, InitSel, pc} !== {1'b1, 16'h0, 16'h1234, 1'b1, 6'd1}) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: valid=%b instr=%h data=%h init=%b pc=%0d, required valid=1 instr=0000 data=1234 init=1 pc=1",
                         k, issue_valid, Instruction, DataInit, InitSel, pc);
            end
        end
        stall = 1'b0;
        tick();
        tests_run++;
        if (issue_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_gap: valid=%b, required 0", issue_valid);
        end
        tick();
        tests_run++;
        if ({issue_valid, Instruction, pc} !== {1'b1, 16'h3A10, 6'd2}) begin
            tests_failed++;
            $display("FAIL stall_next_entry: valid=%b instr=%h pc=%0d, required valid=1 instr=3a10 pc=2",
                     issue_valid, Instruction, pc);
        end
        tick();
    endtask

    task automatic test_zero_len();
        int seen = 0;
        do_start(0);
        tests_run++;
        if ({done, busy, issue_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL zero_len_done: done=%b busy=%b valid=%b, required done=1 busy=0 valid=0",
                     done, busy, issue_valid);
        end
        for (int c = 0; c < 4; c++) begin
            if (issue_valid) seen++;
            tick();
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL zero_len_no_issue: issues=%0d, required 0", seen);
        end
    endtask

    task automatic test_full_len();
        int cnt = 0, errs = 0, last_pc = -1;
        load_pattern();
        do_start(80);
        for (int c = 0; c < 300 && !done; c++) begin
            if (issue_valid) begin
                cnt++;
                if (Instruction !== pat_instr(int'(pc)) || DataInit !== pat_data(int'(pc))) errs++;
                last_pc = int'(pc);
            end
            tick();
        end
        tests_run++;
        if (cnt !== 64 || errs !== 0) begin
            tests_failed++;
            $display("FAIL full_len_count: issues=%0d bad=%0d, required issues=64 bad=0", cnt, errs);
        end
        tests_run++;
        if (last_pc !== 63 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_len_last: last_pc=%0d done=%b, required last_pc=63 done=1", last_pc, done);
        end
    endtask

    task automatic test_abort();
        int c = 0;
        do_start(10);
        while (!(issue_valid && pc == 6'd5) && c < 40) begin
            tick();
            c++;
        end
        tests_run++;
        if (!(issue_valid && pc == 6'd5 && Instruction == pat_instr(5))) begin
            tests_failed++;
            $display("FAIL abort_reach_entry5: valid=%b pc=%0d instr=%h after %0d cycles, required entry 5",
                     issue_valid, pc, Instruction, c);
        end
        abort = 1'b1;
        start = 1'b1;
        prog_len = 7'd10;
        tick();
        abort = 1'b0;
        start = 1'b0;
        tests_run++;
        if ({Instruction, DataInit, InitSel, issue_valid, pc, busy, done} !== '0) begin
            tests_failed++;
            $display("FAIL abort_idle: instr=%h data=%h init=%b valid=%b pc=%0d busy=%b done=%b, required all zero",
                     Instruction, DataInit, InitSel, issue_valid, pc, busy, done);
        end
        tick();
        tests_run++;
        if ({busy, issue_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_stays_idle: busy=%b valid=%b, required 0 0", busy, issue_valid);
        end
        do_start(1);
        tick();
        tests_run++;
        if ({issue_valid, pc, Instruction, DataInit} !== {1'b1, 6'd0, pat_instr(0), pat_data(0)}) begin
            tests_failed++;
            $display("FAIL abort_rerun: valid=%b pc=%0d instr=%h data=%h, required valid=1 pc=0 instr=%h data=%h",
                     issue_valid, pc, Instruction, DataInit, pat_instr(0), pat_data(0));
        end
        tick();
    endtask

    task automatic test_load_during_run();
        int c = 0;
        do_start(4);
        load_we = 1'b1; load_addr = 6'd2;
        load_instr = 16'hDEAD; load_data = 16'hBEEF; load_init = 1'b1;
        tick(); tick(); tick(); tick();
        load_we = 1'b0;
        while (!done && c < 40) begin
            tick();
            c++;
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_run_done: done=%b after %0d cycles, required 1", done, c);
        end
        do_start(3);
        for (int k = 1; k < 6; k++) tick();
        tests_run++;
        if ({issue_valid, pc, Instruction, DataInit, InitSel} !== {1'b1, 6'd2, pat_instr(2), pat_data(2), 1'b0}) begin
            tests_failed++;
            $display("FAIL load_locked: valid=%b pc=%0d instr=%h data=%h init=%b, required valid=1 pc=2 instr=%h data=%h init=0",
                     issue_valid, pc, Instruction, DataInit, InitSel, pat_instr(2), pat_data(2));
        end
        tick();
    endtask

    // Tiny datapath stand-in: InitSel loads the accumulator with DataInit,
    // otherwise the instruction word is added.
    task automatic test_datapath();
        logic [15:0] acc = 16'h0;
        logic [15:0] gold_init [2] = '{16'h0000, 16'h1234};
        int ni = 0, bad = 0;
        load_entry(0, 16'h0000, 16'h0000, 1'b1);
        load_entry(1, 16'h0000, 16'h1234, 1'b1);
        load_entry(2, 16'h3A10, 16'h0000, 1'b0);
        do_start(3);
        for (int c = 0; c < 30 && !done; c++) begin
            if (issue_valid) begin
                if (InitSel) begin
                    if (ni > 1 || DataInit !== gold_init[ni]) bad++;
                    ni++;
                    acc = DataInit;
                end else begin
                    acc = acc + Instruction;
                end
            end
            tick();
        end
        tests_run++;
        if (ni !== 2 || bad !== 0) begin
            tests_failed++;
            $display("FAIL datapath_init: init_entries=%0d bad=%0d, required 2 and 0", ni, bad);
        end
        tests_run++;
        if (acc !== 16'h4C44) begin
            tests_failed++;
            $display("FAIL datapath_aluout: acc=%h, required 4c44", acc);
        end
    endtask

    initial begin
        reset = 1'b0; load_we = 1'b0; load_addr = '0; load_instr = '0;
        load_data = '0; load_init = 1'b0; start = 1'b0; prog_len = '0;
        stall = 1'b0; abort = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_full_len();
        test_abort();
        test_load_during_run();
        test_datapath();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
